// File: rtl/adc_bank_pkg.sv
// Shared types and default parameters for the ADC sample bank.
package adc_bank_pkg;

  typedef enum logic {
    MODE_CONT    = 1'b0,
    MODE_ONESHOT = 1'b1
  } bank_mode_e;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int NTAPS_DEF  = 2;

endpackage

// File: rtl/adc_tap_shift.sv
// NTAPS x DATA_W shift register feeding the newest-sample taps; slice 0 is newest.
// Clear and shift in the same cycle leaves only the incoming sample in slice 0.
module adc_tap_shift
  import adc_bank_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NTAPS  = NTAPS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      shift,
  input  logic [DATA_W-1:0]         din,
  output logic [NTAPS*DATA_W-1:0]   taps
);

  logic [NTAPS*DATA_W-1:0]     taps_r;
  logic [NTAPS*DATA_W-1:0]     taps_nxt_s;
  logic [(NTAPS+1)*DATA_W-1:0] ext_s;

  // next tap contents from clear / shift requests
  always_comb begin
    ext_s = {taps_r, din};
    if (clr && shift) begin
      taps_nxt_s = (NTAPS*DATA_W)'(din);
    end else if (clr) begin
      taps_nxt_s = '0;
    end else if (shift) begin
      taps_nxt_s = ext_s[NTAPS*DATA_W-1:0];
    end else begin
      taps_nxt_s = taps_r;
    end
  end

  // tap register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      taps_r <= '0;
    end else begin
      taps_r <= taps_nxt_s;
    end
  end

  assign taps = taps_r;

endmodule

// File: rtl/adc_sample_bank.sv
// DEPTH-entry circular ADC sample bank with newest-sample taps and a registered read port.
// Optional min/max tracking is enabled by defining ADC_BANK_MINMAX_EN.
module adc_sample_bank
  import adc_bank_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  NTAPS  = NTAPS_DEF,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_W-1:0]         adc_data,
  input  logic                      adc_valid,
  input  logic                      mode,
  input  logic                      arm,
  input  logic                      rd_en,
  input  logic [AW-1:0]             rd_addr,
  output logic [DATA_W-1:0]         rd_data,
  output logic                      rd_valid,
  output logic [NTAPS*DATA_W-1:0]   taps,
  output logic [AW:0]               count,
  output logic                      full,
  output logic                      overflow
`ifdef ADC_BANK_MINMAX_EN
  ,
  output logic [DATA_W-1:0]         min_val,
  output logic [DATA_W-1:0]         max_val
`endif
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_C  = AW'(DEPTH-1);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     wr_ptr_r;
  logic [AW:0]       count_r;
  logic              full_r;
  logic              overflow_r;
  logic [DATA_W-1:0] rd_data_r;
  logic              rd_valid_r;

  bank_mode_e        mode_s;
  logic              wr_accept_s;
  logic [AW-1:0]     wr_addr_s;
  logic [AW-1:0]     wr_ptr_nxt_s;
  logic [AW:0]       count_nxt_s;
  logic              overflow_nxt_s;
  logic              rd_in_range_s;

  // write acceptance and next pointer/count/overflow; arm restarts at address 0
  always_comb begin
    mode_s         = bank_mode_e'(mode);
    wr_accept_s    = adc_valid && (arm || !((mode_s == MODE_ONESHOT) && full_r));
    wr_addr_s      = arm ? {AW{1'b0}} : wr_ptr_r;
    wr_ptr_nxt_s   = wr_ptr_r;
    count_nxt_s    = count_r;
    overflow_nxt_s = overflow_r;
    rd_in_range_s  = ({1'b0, rd_addr} < DEPTH_C);
    if (arm) begin
      overflow_nxt_s = 1'b0;
      if (wr_accept_s) begin
        wr_ptr_nxt_s = AW'(1);
        count_nxt_s  = (AW+1)'(1);
      end else begin
        wr_ptr_nxt_s = {AW{1'b0}};
        count_nxt_s  = {(AW+1){1'b0}};
      end
    end else if (wr_accept_s) begin
      wr_ptr_nxt_s   = (wr_ptr_r == LAST_C) ? {AW{1'b0}} : wr_ptr_r + AW'(1);
      count_nxt_s    = full_r ? count_r : count_r + (AW+1)'(1);
      // an accepted write while full can only happen in continuous mode
      overflow_nxt_s = overflow_r | full_r;
    end else begin
      wr_ptr_nxt_s   = wr_ptr_r;
    end
  end

  // pointer, occupancy and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= {AW{1'b0}};
      count_r    <= {(AW+1){1'b0}};
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wr_ptr_r   <= wr_ptr_nxt_s;
      count_r    <= count_nxt_s;
      full_r     <= (count_nxt_s == DEPTH_C);
      overflow_r <= overflow_nxt_s;
    end
  end

  // sample storage, intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_addr_s] <= adc_data;
    end
  end

  // registered read port; same-cycle write is not forwarded, so old data is returned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= rd_en;
      if (rd_en) begin
        rd_data_r <= rd_in_range_s ? mem_r[rd_addr] : {DATA_W{1'b0}};
      end
    end
  end

  adc_tap_shift #(
    .DATA_W (DATA_W),
    .NTAPS  (NTAPS)
  ) u_taps (
    .clk   (clk),
    .rst   (rst),
    .clr   (arm),
    .shift (wr_accept_s),
    .din   (adc_data),
    .taps  (taps)
  );

`ifdef ADC_BANK_MINMAX_EN
  logic [DATA_W-1:0] min_r;
  logic [DATA_W-1:0] max_r;

  // running extremes; the all-ones/zero start values make the first sample win both
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_r <= {DATA_W{1'b1}};
      max_r <= {DATA_W{1'b0}};
    end else if (arm) begin
      min_r <= wr_accept_s ? adc_data : {DATA_W{1'b1}};
      max_r <= wr_accept_s ? adc_data : {DATA_W{1'b0}};
    end else if (wr_accept_s) begin
      if (adc_data < min_r) begin
        min_r <= adc_data;
      end
      if (adc_data > max_r) begin
        max_r <= adc_data;
      end
    end
  end

  assign min_val = min_r;
  assign max_val = max_r;
`endif

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign count    = count_r;
  assign full     = full_r;
  assign overflow = overflow_r;

endmodule
